// File: rtl/encoder_sys.sv
// Rate 1/2 convolutional encoder with selectable constraint length K=3..6.
// Frames of FRAME_BITS data bits are flushed with K-1 zero tail symbols.
module encoder_sys #(
    parameter int unsigned FRAME_BITS = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] choose_constraint_length,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic [1:0] encoded_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    localparam logic [8:0] FRAME_LEN = 9'(FRAME_BITS);

    logic [1:0] state_q, state_d;
    logic [4:0] sr_q, sr_d;
    logic [7:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] tail_cnt_q, tail_cnt_d;
    logic [2:0] k_q, k_d;
    logic [1:0] enc_q, enc_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;

    logic       slot_free;
    logic       accept;
    logic       tail_emit;
    logic       out_fire;
    logic [2:0] k_sel;
    logic [2:0] k_use;
    logic [8:0] cnt_next;

    function automatic logic [2:0] map_k(input logic [2:0] sel);
        logic [2:0] k;
        if (sel < 3'd3) begin
            k = 3'd3;
        end else if (sel == 3'd7) begin
            k = 3'd6;
        end else begin
            k = sel;
        end
        return k;
    endfunction

    // Window puts the current input at w[K-1] and older bits below it.
    function automatic logic [1:0] encode(input logic u, input logic [4:0] sr,
                                          input logic [2:0] k);
        logic [5:0] w;
        logic [5:0] g0;
        logic [5:0] g1;
        case (k)
            3'd4: begin
                w  = {2'b00, u, sr[0], sr[1], sr[2]};
                g0 = 6'o15;
                g1 = 6'o17;
            end
            3'd5: begin
                w  = {1'b0, u, sr[0], sr[1], sr[2], sr[3]};
                g0 = 6'o23;
                g1 = 6'o35;
            end
            3'd6: begin
                w  = {u, sr[0], sr[1], sr[2], sr[3], sr[4]};
                g0 = 6'o53;
                g1 = 6'o75;
            end
            default: begin
                w  = {3'b000, u, sr[0], sr[1]};
                g0 = 6'o07;
                g1 = 6'o05;
            end
        endcase
        return {^(w & g0), ^(w & g1)};
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign out_fire  = out_valid_q && out_ready;
    // rst_n gating keeps in_ready low throughout reset and high right after release.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && slot_free;
    assign accept    = in_valid && in_ready;
    assign tail_emit = (state_q == ST_TAIL) && slot_free && (tail_cnt_q < (k_q - 3'd1));
    assign k_sel     = map_k(choose_constraint_length);
    assign k_use     = (state_q == ST_IDLE) ? k_sel : k_q;
    assign cnt_next  = ((state_q == ST_IDLE) ? 9'd0 : {1'b0, bit_cnt_q}) + 9'd1;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        k_d         = k_q;
        enc_d       = enc_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            enc_d       = encode(in_bit, sr_q, k_use);
            sr_d        = {sr_q[3:0], in_bit};
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            bit_cnt_d   = cnt_next[7:0];
            if (state_q == ST_IDLE) begin
                k_d = k_sel;
            end
            if (cnt_next == FRAME_LEN) begin
                state_d    = ST_TAIL;
                tail_cnt_d = 3'd0;
            end else begin
                state_d = ST_DATA;
            end
        end else if (tail_emit) begin
            enc_d       = encode(1'b0, sr_q, k_q);
            sr_d        = {sr_q[3:0], 1'b0};
            out_valid_d = 1'b1;
            out_last_d  = (tail_cnt_q == (k_q - 3'd2));
            tail_cnt_d  = tail_cnt_q + 3'd1;
        end

        // Frame closes only once the final tail symbol has been taken downstream.
        if ((state_q == ST_TAIL) && out_fire && out_last_q) begin
            state_d    = ST_IDLE;
            sr_d       = 5'd0;
            bit_cnt_d  = 8'd0;
            tail_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= 5'd0;
            bit_cnt_q   <= 8'd0;
            tail_cnt_q  <= 3'd0;
            k_q         <= 3'd3;
            enc_q       <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            k_q         <= k_d;
            enc_q       <= enc_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign encoded_bits = enc_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;

endmodule
